// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter slice.
//   WB_ADDR_W / WB_DATA_W : default register index / data widths
//   SRC_ALU / SRC_LSU     : source index constants (also round-robin pointer values)
//   wb_entry_t            : queued writeback entry {addr, data}
package wb_pkg;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle of the writeback arbiter.
//   src0_* : ALU result handshake (valid/ready, addr, data)
//   src1_* : LSU/MDU result handshake (valid/ready, addr, data)
//   rf_*   : registered register-file write port
//   q_addr_* / pend_hit_* : pending-write hazard queries
// Modports: slave = arbiter side, master = producer/issue side.
interface wb_arbiter_if #(
  parameter int ADDR_W = wb_pkg::WB_ADDR_W,
  parameter int DATA_W = wb_pkg::WB_DATA_W
) ();
  import wb_pkg::*;

  logic              src0_valid;
  logic              src0_ready;
  logic [ADDR_W-1:0] src0_addr;
  logic [DATA_W-1:0] src0_data;
  logic              src1_valid;
  logic              src1_ready;
  logic [ADDR_W-1:0] src1_addr;
  logic [DATA_W-1:0] src1_data;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_addr_w;
  logic [DATA_W-1:0] rf_data_w;
  logic [ADDR_W-1:0] q_addr_a;
  logic [ADDR_W-1:0] q_addr_b;
  logic              pend_hit_a;
  logic              pend_hit_b;

  modport slave (
    input  src0_valid, src0_addr, src0_data,
    input  src1_valid, src1_addr, src1_data,
    input  q_addr_a, q_addr_b,
    output src0_ready, src1_ready,
    output rf_wen, rf_addr_w, rf_data_w,
    output pend_hit_a, pend_hit_b
  );

  modport master (
    output src0_valid, src0_addr, src0_data,
    output src1_valid, src1_addr, src1_data,
    output q_addr_a, q_addr_b,
    input  src0_ready, src1_ready,
    input  rf_wen, rf_addr_w, rf_data_w,
    input  pend_hit_a, pend_hit_b
  );
endinterface

// File: rtl/wb_queue.sv
// In-order writeback queue for one result producer.
//   clk, rst   : clock, asynchronous active-high reset (empties the queue)
//   push       : enqueue push_addr/push_data (caller guarantees !full)
//   pop        : dequeue the head entry (caller guarantees !empty)
//   full/empty : derived from the registered occupancy count
//   head_*     : oldest entry
//   ent_vld/ent_addr : per-slot occupancy and destination, for hazard compare
module wb_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [ADDR_W-1:0]            push_addr,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [ADDR_W-1:0]            head_addr,
  output logic [DATA_W-1:0]            head_data,
  output logic [DEPTH-1:0]             ent_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr
);
  import wb_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // Slot i is occupied when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off      = '0;
    ent_vld  = '0;
    ent_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PTR_W'(i) - rd_ptr;
      ent_vld[i]  = ({1'b0, off} < count);
      ent_addr[i] = mem_addr[i];
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two producer queues (ALU, LSU/MDU) share one registered
// register-file write port under round-robin arbitration.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wb_arbiter_if.slave -- producer handshakes, rf write port,
//              pending-write hazard queries
module wb_arbiter #(
  parameter int DATA_W = wb_pkg::WB_DATA_W,
  parameter int ADDR_W = wb_pkg::WB_ADDR_W,
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  import wb_pkg::*;

  logic                          push0, push1;
  logic                          full0, full1;
  logic                          empty0, empty1;
  logic [ADDR_W-1:0]             head_addr0, head_addr1;
  logic [DATA_W-1:0]             head_data0, head_data1;
  logic [QDEPTH-1:0]             ent_vld0, ent_vld1;
  logic [QDEPTH-1:0][ADDR_W-1:0] ent_addr0, ent_addr1;

  logic              gnt0_p0, gnt1_p0;
  logic              prio_q, prio_d;   // source preferred when both queues hold data
  logic              wr_vld_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [DATA_W-1:0] wr_data_p1;

  // Ready looks only at registered occupancy, never at a same-cycle pop.
  assign bus.src0_ready = !rst && !full0;
  assign bus.src1_ready = !rst && !full1;

  // Writes to x0 complete the handshake but are discarded.
  assign push0 = bus.src0_valid && bus.src0_ready && (bus.src0_addr != '0);
  assign push1 = bus.src1_valid && bus.src1_ready && (bus.src1_addr != '0);

  wb_queue #(.DEPTH(QDEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_q_alu (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_addr (bus.src0_addr),
    .push_data (bus.src0_data),
    .pop       (gnt0_p0),
    .full      (full0),
    .empty     (empty0),
    .head_addr (head_addr0),
    .head_data (head_data0),
    .ent_vld   (ent_vld0),
    .ent_addr  (ent_addr0)
  );

  wb_queue #(.DEPTH(QDEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_q_lsu (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_addr (bus.src1_addr),
    .push_data (bus.src1_data),
    .pop       (gnt1_p0),
    .full      (full1),
    .empty     (empty1),
    .head_addr (head_addr1),
    .head_data (head_data1),
    .ent_vld   (ent_vld1),
    .ent_addr  (ent_addr1)
  );

  // ---- p0: arbitration on registered queue state ----
  always_comb begin
    gnt0_p0 = !empty0 && (empty1 || (prio_q == SRC_ALU));
    gnt1_p0 = !empty1 && (empty0 || (prio_q == SRC_LSU));
    prio_d  = prio_q;
    if (gnt0_p0)      prio_d = SRC_LSU;
    else if (gnt1_p0) prio_d = SRC_ALU;
  end

  // ---- p1: registered write port ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= SRC_ALU;
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      prio_q    <= prio_d;
      wr_vld_p1 <= gnt0_p0 || gnt1_p0;
      if (gnt0_p0) begin
        wr_addr_p1 <= head_addr0;
        wr_data_p1 <= head_data0;
      end else if (gnt1_p0) begin
        wr_addr_p1 <= head_addr1;
        wr_data_p1 <= head_data1;
      end
    end
  end

  assign bus.rf_wen    = wr_vld_p1;
  assign bus.rf_addr_w = wr_addr_p1;
  assign bus.rf_data_w = wr_data_p1;

  // A write is pending while queued in either source or sitting on the port.
  function automatic logic pend_match(
    input logic [ADDR_W-1:0]             q,
    input logic [QDEPTH-1:0]             vld0,
    input logic [QDEPTH-1:0][ADDR_W-1:0] addr0,
    input logic [QDEPTH-1:0]             vld1,
    input logic [QDEPTH-1:0][ADDR_W-1:0] addr1,
    input logic                          wen,
    input logic [ADDR_W-1:0]             waddr
  );
    logic hit;
    hit = wen && (waddr == q);
    for (int i = 0; i < QDEPTH; i++) begin
      hit = hit || (vld0[i] && (addr0[i] == q)) || (vld1[i] && (addr1[i] == q));
    end
    return hit && (q != '0);
  endfunction

  assign bus.pend_hit_a = pend_match(bus.q_addr_a, ent_vld0, ent_addr0, ent_vld1, ent_addr1,
                                     wr_vld_p1, wr_addr_p1);
  assign bus.pend_hit_b = pend_match(bus.q_addr_b, ent_vld0, ent_addr0, ent_vld1, ent_addr1,
                                     wr_vld_p1, wr_addr_p1);
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int QDEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq0[$];
  ent_t              mq1[$];
  logic              m_pref1 = 1'b0;  // 1: src1 wins next tie
  logic              m_wen   = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [DATA_W-1:0] m_data  = '0;
  logic              m_acc0  = 1'b0;
  logic              m_acc1  = 1'b0;
  int                cyc     = 0;
  ent_t              wlog[$];
  int                wcyc[$];

  always @(posedge clk or posedge rst) begin
    int   n0, n1, g;
    ent_t e;
    if (rst) begin
      mq0.delete();
      mq1.delete();
      m_pref1 = 1'b0;
      m_wen   = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_acc0  = 1'b0;
      m_acc1  = 1'b0;
    end else begin
      cyc++;
      n0 = mq0.size();
      n1 = mq1.size();
      g  = -1;
      if (n0 > 0 && n1 > 0) g = m_pref1 ? 1 : 0;
      else if (n0 > 0)      g = 0;
      else if (n1 > 0)      g = 1;
      m_acc0 = bus.src0_valid && (n0 < QDEPTH);
      m_acc1 = bus.src1_valid && (n1 < QDEPTH);
      if (g == 0) e = mq0.pop_front();
      else if (g == 1) e = mq1.pop_front();
      if (g >= 0) begin
        m_wen   = 1'b1;
        m_addr  = e.a;
        m_data  = e.d;
        m_pref1 = (g == 0);
        wlog.push_back(e);
        wcyc.push_back(cyc);
      end else begin
        m_wen = 1'b0;
      end
      if (m_acc0 && bus.src0_addr != '0) mq0.push_back('{bus.src0_addr, bus.src0_data});
      if (m_acc1 && bus.src1_addr != '0) mq1.push_back('{bus.src1_addr, bus.src1_data});
    end
  end

  function automatic logic exp_pend(input logic [ADDR_W-1:0] q);
    if (q == '0) return 1'b0;
    foreach (mq0[i]) if (mq0[i].a == q) return 1'b1;
    foreach (mq1[i]) if (mq1[i].a == q) return 1'b1;
    return m_wen && (m_addr == q);
  endfunction

  // ---------------- per-cycle compare ----------------
  int   dut_wcnt     = 0;
  logic saw_rdy1_low = 1'b0;

  always @(negedge clk) begin
    chk("rf_wen",     32'(bus.rf_wen),     32'(m_wen));
    chk("rf_addr_w",  32'(bus.rf_addr_w),  32'(m_addr));
    chk("rf_data_w",  bus.rf_data_w,       m_data);
    chk("src0_ready", 32'(bus.src0_ready), 32'(!rst && mq0.size() < QDEPTH));
    chk("src1_ready", 32'(bus.src1_ready), 32'(!rst && mq1.size() < QDEPTH));
    chk("pend_hit_a", 32'(bus.pend_hit_a), 32'(exp_pend(bus.q_addr_a)));
    chk("pend_hit_b", 32'(bus.pend_hit_b), 32'(exp_pend(bus.q_addr_b)));
    if (bus.rf_wen) dut_wcnt++;
    if (!rst && !bus.src1_ready) saw_rdy1_low = 1'b1;
  end

  // ---------------- drivers ----------------
  logic [ADDR_W-1:0] s0a[16];
  logic [DATA_W-1:0] s0d[16];
  int                s0n = 0;
  logic [ADDR_W-1:0] s1a[16];
  logic [DATA_W-1:0] s1d[16];
  int                s1n = 0;

  task automatic drv0();
    for (int i = 0; i < s0n; i++) begin
      int t;
      t = 0;
      bus.src0_valid = 1'b1;
      bus.src0_addr  = s0a[i];
      bus.src0_data  = s0d[i];
      do begin
        @(posedge clk); #1;
        t++;
      end while (!m_acc0 && t < 50);
      if (!m_acc0) begin
        checks++; errors++;
        $display("FAIL drv0_timeout: entry %0d not accepted after %0d cycles", i, t);
      end
    end
    bus.src0_valid = 1'b0;
  endtask

  task automatic drv1();
    for (int i = 0; i < s1n; i++) begin
      int t;
      t = 0;
      bus.src1_valid = 1'b1;
      bus.src1_addr  = s1a[i];
      bus.src1_data  = s1d[i];
      do begin
        @(posedge clk); #1;
        t++;
      end while (!m_acc1 && t < 50);
      if (!m_acc1) begin
        checks++; errors++;
        $display("FAIL drv1_timeout: entry %0d not accepted after %0d cycles", i, t);
      end
    end
    bus.src1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((mq0.size() != 0 || mq1.size() != 0 || m_wen) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_in_time", 32'(t < 100), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int wc;
    logic [ADDR_W-1:0] bp_seen[$];
    logic [DATA_W-1:0] cont_d[8];

    bus.src0_valid = 1'b0; bus.src0_addr = '0; bus.src0_data = '0;
    bus.src1_valid = 1'b0; bus.src1_addr = '0; bus.src1_data = '0;
    bus.q_addr_a   = '0;   bus.q_addr_b  = '0;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_wen",   32'(bus.rf_wen),     32'd0);
    chk("rst_rf_addr",  32'(bus.rf_addr_w),  32'd0);
    chk("rst_rf_data",  bus.rf_data_w,       32'd0);
    chk("rst_rdy0",     32'(bus.src0_ready), 32'd0);
    chk("rst_rdy1",     32'(bus.src1_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_rdy0", 32'(bus.src0_ready), 32'd1);
    chk("rel_rdy1", 32'(bus.src1_ready), 32'd1);

    // contention: 1..8 interleaved starting with src0
    s0a = '{default: '0}; s1a = '{default: '0};
    s0d = '{default: '0}; s1d = '{default: '0};
    s0a[0] = 5'd1; s0a[1] = 5'd3; s0a[2] = 5'd5; s0a[3] = 5'd7;
    s1a[0] = 5'd2; s1a[1] = 5'd4; s1a[2] = 5'd6; s1a[3] = 5'd8;
    for (int i = 0; i < 4; i++) begin
      s0d[i] = 32'h10 + 32'(i);
      s1d[i] = 32'h20 + 32'(i);
    end
    s0n = 4; s1n = 4;
    cont_d = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12, 32'h22, 32'h13, 32'h23};
    base = wlog.size();
    fork
      drv0();
      drv1();
    join
    wait_idle();
    chk("cont_count", 32'(wlog.size() - base), 32'd8);
    if (wlog.size() - base == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("cont_addr", 32'(wlog[base+i].a), 32'(i + 1));
        chk("cont_data", wlog[base+i].d, cont_d[i]);
        if (i > 0) chk("cont_back2back", 32'(wcyc[base+i] - wcyc[base+i-1]), 32'd1);
      end
    end

    // single write
    @(posedge clk); #1;
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd5; bus.src0_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.src0_valid = 1'b0;
    chk("single_wen_e0", 32'(bus.rf_wen), 32'd0);
    @(posedge clk); #1;
    chk("single_wen",  32'(bus.rf_wen),    32'd1);
    chk("single_addr", 32'(bus.rf_addr_w), 32'd5);
    chk("single_data", bus.rf_data_w,      32'hDEADBEEF);
    @(posedge clk); #1;
    chk("single_wen_off",  32'(bus.rf_wen),    32'd0);
    chk("single_addr_hold", 32'(bus.rf_addr_w), 32'd5);

    // x0 drop
    bus.q_addr_a = '0;
    wc = dut_wcnt;
    bus.src1_valid = 1'b1; bus.src1_addr = '0; bus.src1_data = 32'h1234;
    @(posedge clk); #1;
    bus.src1_valid = 1'b0;
    chk("x0_handshake", 32'(m_acc1),          32'd1);
    chk("x0_rdy1",      32'(bus.src1_ready),  32'd1);
    chk("x0_pend_a",    32'(bus.pend_hit_a),  32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("x0_no_write", 32'(dut_wcnt - wc), 32'd0);

    // backpressure on src1 while src0 floods
    for (int i = 0; i < 8; i++) begin
      s0a[i] = 5'(12 + i);
      s0d[i] = 32'h100 + 32'(i);
    end
    s1a[0] = 5'd9; s1a[1] = 5'd10; s1a[2] = 5'd11;
    s1d[0] = 32'h90; s1d[1] = 32'h91; s1d[2] = 32'h92;
    s0n = 8; s1n = 3;
    saw_rdy1_low = 1'b0;
    base = wlog.size();
    fork
      drv0();
      drv1();
    join
    wait_idle();
    chk("bp_rdy1_dropped", 32'(saw_rdy1_low), 32'd1);
    chk("bp_total", 32'(wlog.size() - base), 32'd11);
    for (int i = base; i < wlog.size(); i++)
      if (wlog[i].a >= 5'd9 && wlog[i].a <= 5'd11) bp_seen.push_back(wlog[i].a);
    chk("bp_src1_count", 32'(bp_seen.size()), 32'd3);
    if (bp_seen.size() == 3) begin
      chk("bp_order0", 32'(bp_seen[0]), 32'd9);
      chk("bp_order1", 32'(bp_seen[1]), 32'd10);
      chk("bp_order2", 32'(bp_seen[2]), 32'd11);
    end

    // hazard window
    bus.q_addr_a = 5'd7; bus.q_addr_b = 5'd8;
    @(posedge clk); #1;
    chk("hz_pend_a_idle", 32'(bus.pend_hit_a), 32'd0);
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd7; bus.src0_data = 32'h77;
    @(posedge clk); #1;
    bus.src0_valid = 1'b0;
    chk("hz_pend_a_queued", 32'(bus.pend_hit_a), 32'd1);
    chk("hz_pend_b_queued", 32'(bus.pend_hit_b), 32'd0);
    @(posedge clk); #1;
    chk("hz_wen",          32'(bus.rf_wen),     32'd1);
    chk("hz_addr",         32'(bus.rf_addr_w),  32'd7);
    chk("hz_pend_a_write", 32'(bus.pend_hit_a), 32'd1);
    chk("hz_pend_b_write", 32'(bus.pend_hit_b), 32'd0);
    @(posedge clk); #1;
    chk("hz_pend_a_done", 32'(bus.pend_hit_a), 32'd0);

    // reset mid-traffic
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd20; bus.src0_data = 32'hA0;
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd21; bus.src1_data = 32'hB0;
    repeat (4) @(posedge clk);
    #1;
    bus.src0_valid = 1'b0; bus.src1_valid = 1'b0;
    chk("mid_wen_before", 32'(bus.rf_wen), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wen",  32'(bus.rf_wen),     32'd0);
    chk("mid_rst_addr", 32'(bus.rf_addr_w),  32'd0);
    chk("mid_rst_data", bus.rf_data_w,       32'd0);
    chk("mid_rst_rdy0", 32'(bus.src0_ready), 32'd0);
    chk("mid_rst_rdy1", 32'(bus.src1_ready), 32'd0);
    wc = dut_wcnt;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rel_rdy0", 32'(bus.src0_ready), 32'd1);
    chk("mid_rel_rdy1", 32'(bus.src1_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_no_writes", 32'(dut_wcnt - wc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback arbiter that drives the register file write port (rf_wen / rf_addr_w / rf_data_w) on behalf of two result producers: src0 is the ALU and src1 is the LSU/MDU.
- Each producer pushes results through a valid/ready handshake into its own small in-order queue.
- A round-robin arbiter pops at most one entry per cycle into registered write-port outputs.
- Pending-write query ports let issue logic detect RAW/WAW hazards against results that are queued but not yet written.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
QDEPTH, 2, entries per source queue (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
src0_valid  in  1  ALU result valid
src0_ready  out  1  ALU queue can accept
src0_addr  in  ADDR_W  destination register
src0_data  in  DATA_W  result
src1_valid  in  1  LSU/MDU result valid
src1_ready  out  1  LSU/MDU queue can accept
src1_addr  in  ADDR_W  destination register
src1_data  in  DATA_W  result
rf_wen  out  1  register file write enable (registered)
rf_addr_w  out  ADDR_W  write index (registered)
rf_data_w  out  DATA_W  write data (registered)
q_addr_a  in  ADDR_W  hazard query A
q_addr_b  in  ADDR_W  hazard query B
pend_hit_a  out  1  write to q_addr_a is pending
pend_hit_b  out  1  write to q_addr_b is pending

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high.
  - While rst=1: both queues empty, rf_wen=0, rf_addr_w=0, rf_data_w=0, round-robin pointer selects src0 first, src*_ready=0, pend_hit_*=0.
  - Reset mid-operation discards all queued entries silently.
- Handshake:
  - srcN_ready = !rst && (countN < QDEPTH).
  - Ready depends only on the registered count. A same-cycle pop never raises ready on a full queue.
  - Transfer occurs on the rising edge where valid && ready.
  - Producers hold addr/data stable while valid && !ready.
- x0 filtering: a transfer with addr==0 completes the handshake but is not enqueued. It never produces rf_wen and never sets pend_hit.
- Queues: FIFO per source with wrap-around read/write pointers of width log2(QDEPTH) and count of width log2(QDEPTH)+1. Push and pop of the same queue in one edge leave count unchanged.
- Arbitration, evaluated each cycle on registered queue state:
  - Both non-empty: grant the source not granted last, then flip the pointer.
  - One non-empty: grant it; the pointer records that source.
  - None non-empty: no grant; the pointer is unchanged.
- Write port:
  - On the edge following a grant, the head entry is popped and rf_wen=1, rf_addr_w, rf_data_w are loaded from it.
  - With no grant, rf_wen=0 and addr/data hold their previous values.
- Latency: a result accepted at edge E0 can be granted in cycle E0..E1 and drives rf_wen in cycle E1..E2; the register file commits at E2.
  - Minimum accept-to-commit is 2 edges.
  - Sustained throughput is 1 write per cycle total.
  - Each source gets at least 1 write per 2 cycles under contention, so there is no starvation.
- Ordering:
  - Per-source order is preserved.
  - Cross-source order is not guaranteed. Issue logic must use pend_hit to avoid WAW across sources.
- Pending query (combinational): pend_hit_x=1 iff q_addr_x!=0 and it matches any occupied queue entry of either source, or matches rf_addr_w while rf_wen=1.
- Simultaneous events: push into an empty queue and a grant of the other queue in the same cycle are independent. A newly pushed entry is not eligible for grant until the next cycle.

Decomposition:
- Shared package wb_pkg: WB_ADDR_W, WB_DATA_W, source index constants SRC_ALU=0 and SRC_LSU=1, and the queue entry struct {addr, data}.
- One natural sub-module, wb_queue: parameterised FIFO exposing push/pop/full/empty, head entry, and a per-entry valid+addr vector for the hazard compare. It is instantiated once per source.
- Arbiter, output registers and hazard compare stay in wb_arbiter.

Test Plan:
- Reset mid-traffic: fill both queues, assert rst for 1 cycle -> rf_wen=0, rf_addr_w=0, rf_data_w=0 immediately (async); srcN_ready=0 during rst and 1 after release; no queued entry is ever written.
- Single write: src0 addr=5 data=0xDEADBEEF accepted at E0 -> rf_wen=1, rf_addr_w=5, rf_data_w=0xDEADBEEF for exactly the cycle E1..E2, then rf_wen=0.
- Contention: both sources valid every cycle (src0 addrs 1,3,5,7 with data 0x10..; src1 addrs 2,4,6,8 with data 0x20..) -> write sequence 1,2,3,4,5,6,7,8 starting with src0; rf_wen is continuous once started; each source's order is preserved.
- x0 drop: src1 addr=0 data=0x1234 -> handshake completes, src1_ready stays 1, rf_wen never asserts, pend_hit_a=0 for q_addr_a=0.
- Backpressure, QDEPTH=2: src1 pushes addrs 9,10,11 back-to-back while src0 floods -> src1_ready drops with 2 entries queued; entry 11 is accepted only after a src1 pop; writes to 9,10,11 all appear, in order.
- Hazard: src0 addr=7 enqueued, q_addr_a=7 -> pend_hit_a=1 from the cycle after acceptance through the cycle rf_wen=1 with rf_addr_w=7, then 0; q_addr_b=8 -> pend_hit_b=0 throughout.
